// File: rtl/prescaled_tick_timer.sv
// prescaled_tick_timer: down-counter advanced by resynchronised rising edges of a prescaled tick clock
// Expiry is signalled by a one-cycle pulse; one-shot or auto-reload modes are supported.
module prescaled_tick_timer #(
  parameter int C_CNT_WIDTH   = 16,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic                   i_aclk,
  input  logic                   i_aresetn,
  input  logic                   i_tick_clk,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_auto_reload,
  input  logic [C_CNT_WIDTH-1:0] i_load_value,
  output logic [C_CNT_WIDTH-1:0] o_count,
  output logic                   o_running,
  output logic                   o_tick,
  output logic                   o_expired
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [2:0] C_ARM = 3'(C_SYNC_STAGES + 1);
  localparam logic [C_CNT_WIDTH-1:0] C_ONE = C_CNT_WIDTH'(1);
  logic [C_SYNC_STAGES-1:0] r_sync;
  logic                     r_prev;
  logic [2:0]               r_arm_cnt;
  state_t                   r_state;
  logic [C_CNT_WIDTH-1:0]   r_count;
  logic [C_CNT_WIDTH-1:0]   r_load;
  logic                     r_ar;
  logic                     r_running;
  logic                     r_tick;
  logic                     r_expired;
  logic                     w_armed;
  logic                     w_edge;
  logic                     w_load_ok;
  assign w_armed   = r_arm_cnt == C_ARM;
  assign w_edge    = r_sync[C_SYNC_STAGES-1] & ~r_prev & w_armed;
  assign w_load_ok = i_start & (i_load_value != '0);
  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_tick    = r_tick;
  assign o_expired = r_expired;
  // prev keeps tracking while unarmed so a level held high through reset never looks like an edge
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync[0] <= i_tick_clk;
      for (int i = 1; i < C_SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev    <= r_sync[C_SYNC_STAGES-1];
      r_arm_cnt <= w_armed ? r_arm_cnt : r_arm_cnt + 3'd1;
    end
  end
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_load    <= '0;
      r_ar      <= 1'b0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_tick    <= w_edge;
      r_expired <= 1'b0;
      if (r_state == IDLE) begin
        if (w_load_ok && !i_stop) begin
          r_count   <= i_load_value;
          r_load    <= i_load_value;
          r_ar      <= i_auto_reload;
          r_state   <= RUN;
          r_running <= 1'b1;
        end
      end else if (i_stop) begin
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else if (w_load_ok) begin
        r_count <= i_load_value;
        r_load  <= i_load_value;
        r_ar    <= i_auto_reload;
      end else if (w_edge) begin
        if (r_count != C_ONE) r_count <= r_count - C_ONE;
        else begin
          r_expired <= 1'b1;
          r_count   <= r_ar ? r_load : '0;
          r_state   <= r_ar ? RUN : IDLE;
          r_running <= r_ar;
        end
      end
    end
  end
endmodule

// File: tb/tb_prescaled_tick_timer.sv
// tb_prescaled_tick_timer: directed scenarios for the prescaled tick timer
module tb_prescaled_tick_timer;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tick_clk = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count;
  logic        running;
  logic        tick;
  logic        expired;
  int          errors = 0;
  int          checks = 0;

  prescaled_tick_timer #(.C_CNT_WIDTH(16), .C_SYNC_STAGES(2)) dut (
    .i_aclk(aclk), .i_aresetn(aresetn), .i_tick_clk(tick_clk), .i_start(start),
    .i_stop(stop), .i_auto_reload(auto_reload), .i_load_value(load_value),
    .o_count(count), .o_running(running), .o_tick(tick), .o_expired(expired)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // one-cycle high pulse on tick_clk; returns in the cycle where its tick is visible
  task automatic rise();
    tick_clk = 1'b1;
    step();
    tick_clk = 1'b0;
    step();
    step();
  endtask

  task automatic do_start(input logic [15:0] l, input logic ar);
    start = 1'b1;
    load_value = l;
    auto_reload = ar;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    tick_clk = 1'b1;
    aresetn = 1'b0;
    repeat (3) step();
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b exp=0", expired); end
    aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL held_high_no_tick cycle=%0d got=%b exp=0", c, tick); end
    end
    tick_clk = 1'b0;
    step();
    step();
  endtask

  task automatic test_one_shot();
    do_start(16'd3, 1'b0);
    checks++; if (count !== 16'd3 || running !== 1'b1) begin errors++; $display("FAIL os_start got count=%0d run=%b exp 3/1", count, running); end
    for (int i = 1; i <= 3; i++) begin
      rise();
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL os_tick rise=%0d got=%b exp=1", i, tick); end
      checks++; if (count !== 16'(3 - i)) begin errors++; $display("FAIL os_count rise=%0d got=%0d exp=%0d", i, count, 3 - i); end
      checks++; if (expired !== (i == 3)) begin errors++; $display("FAIL os_expired rise=%0d got=%b exp=%b", i, expired, i == 3); end
      checks++; if (running !== (i != 3)) begin errors++; $display("FAIL os_running rise=%0d got=%b exp=%b", i, running, i != 3); end
    end
    step();
    checks++; if (expired !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL os_pulse_width got exp=%b tick=%b exp 0/0", expired, tick); end
  endtask

  task automatic test_auto_reload();
    do_start(16'd2, 1'b1);
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL ar_start got=%0d exp=2", count); end
    for (int i = 1; i <= 6; i++) begin
      rise();
      checks++; if (count !== ((i % 2) ? 16'd1 : 16'd2)) begin errors++; $display("FAIL ar_count rise=%0d got=%0d exp=%0d", i, count, (i % 2) ? 1 : 2); end
      checks++; if (expired !== (i % 2 == 0)) begin errors++; $display("FAIL ar_expired rise=%0d got=%b exp=%b", i, expired, i % 2 == 0); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL ar_running rise=%0d got=%b exp=1", i, running); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (running !== 1'b0 || count !== 16'd2) begin errors++; $display("FAIL ar_stop got run=%b count=%0d exp 0/2", running, count); end
  endtask

  task automatic test_latency();
    do_start(16'd5, 1'b0);
    tick_clk = 1'b1;
    step();
    checks++; if (tick !== 1'b0 || count !== 16'd5) begin errors++; $display("FAIL lat_k got tick=%b count=%0d exp 0/5", tick, count); end
    step();
    checks++; if (tick !== 1'b0 || count !== 16'd5) begin errors++; $display("FAIL lat_k1 got tick=%b count=%0d exp 0/5", tick, count); end
    step();
    checks++; if (tick !== 1'b1 || count !== 16'd4) begin errors++; $display("FAIL lat_k2 got tick=%b count=%0d exp 1/4", tick, count); end
    step();
    checks++; if (tick !== 1'b0 || count !== 16'd4) begin errors++; $display("FAIL lat_k3 got tick=%b count=%0d exp 0/4", tick, count); end
    tick_clk = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_collisions();
    do_start(16'd5, 1'b0);
    rise();
    start = 1'b1;
    stop = 1'b1;
    load_value = 16'd9;
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++; if (count !== 16'd4 || running !== 1'b0) begin errors++; $display("FAIL start_stop got count=%0d run=%b exp 4/0", count, running); end
    step();
    checks++; if (count !== 16'd4 || running !== 1'b0) begin errors++; $display("FAIL start_stop_hold got count=%0d run=%b exp 4/0", count, running); end
    do_start(16'd6, 1'b0);
    tick_clk = 1'b1;
    step();
    tick_clk = 1'b0;
    step();
    do_start(16'd3, 1'b0);
    checks++; if (count !== 16'd3 || tick !== 1'b1 || expired !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL restart_edge got count=%0d tick=%b exp=%b run=%b exp 3/1/0/1", count, tick, expired, running);
    end
    tick_clk = 1'b1;
    step();
    tick_clk = 1'b0;
    step();
    do_start(16'd0, 1'b0);
    checks++; if (count !== 16'd2 || running !== 1'b1) begin errors++; $display("FAIL zero_start_run got count=%0d run=%b exp 2/1", count, running); end
    stop = 1'b1;
    step();
    checks++; if (count !== 16'd2 || running !== 1'b0) begin errors++; $display("FAIL stop_run got count=%0d run=%b exp 2/0", count, running); end
    step();
    stop = 1'b0;
    checks++; if (count !== 16'd2 || running !== 1'b0) begin errors++; $display("FAIL stop_idle got count=%0d run=%b exp 2/0", count, running); end
    do_reset();
    do_start(16'd0, 1'b0);
    step();
    checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL zero_start_idle got count=%0d run=%b exp 0/0", count, running); end
    rise();
    checks++; if (tick !== 1'b1 || count !== 16'd0 || expired !== 1'b0) begin errors++; $display("FAIL idle_edge got tick=%b count=%0d exp=%b exp 1/0/0", tick, count, expired); end
  endtask

  task automatic test_reset_mid_count();
    do_start(16'd7, 1'b0);
    rise();
    rise();
    checks++; if (count !== 16'd5) begin errors++; $display("FAIL mid_pre got=%0d exp=5", count); end
    aresetn = 1'b0;
    step();
    checks++; if (count !== 16'd0 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL mid_reset got count=%0d run=%b exp=%b exp 0/0/0", count, running, expired); end
    step();
    aresetn = 1'b1;
    repeat (4) step();
    checks++; if (count !== 16'd0 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL mid_after got count=%0d run=%b exp=%b exp 0/0/0", count, running, expired); end
  endtask

  task automatic test_fastest();
    int ticks = 0;
    int exps = 0;
    int ticks_at_exp = -1;
    do_start(16'd4, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick_clk = (c < 8) ? ~tick_clk : 1'b0;
      step();
      if (tick) ticks++;
      if (expired) begin exps++; ticks_at_exp = ticks; end
    end
    checks++; if (ticks !== 4) begin errors++; $display("FAIL fast_ticks got=%0d exp=4", ticks); end
    checks++; if (exps !== 1) begin errors++; $display("FAIL fast_expired got=%0d exp=1", exps); end
    checks++; if (ticks_at_exp !== 4) begin errors++; $display("FAIL fast_exp_on_tick got=%0d exp=4", ticks_at_exp); end
    checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL fast_final got count=%0d run=%b exp 0/0", count, running); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_latency();
    test_collisions();
    test_reset_mid_count();
    test_fastest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
